// File: rtl/sswfmcw_sweep_sched.sv
// Frame/chirp scheduler: sequences N chirps per frame on the TX generator and
// opens the RX capture window a programmable number of sample ticks after chirp start.
module sswfmcw_sweep_sched #(
   parameter int unsigned C_LEN_W = 16,
   parameter int unsigned C_N_W   = 8
) (
   input  logic               CK_i,
   input  logic               ARST_i,
   input  logic               EN_i,
   input  logic               SMP_EE_i,
   input  logic [C_LEN_W-1:0] CHIRP_LEN_i,
   input  logic [C_LEN_W-1:0] GAP_LEN_i,
   input  logic [C_LEN_W-1:0] RX_DLY_i,
   input  logic [C_N_W-1:0]   NCHIRP_i,
   input  logic               TX_RDY_i,
   output logic               TX_START_o,
   output logic               TX_ACT_o,
   output logic               RX_WIN_o,
   output logic [C_N_W-1:0]   CHIRP_IDX_o,
   output logic               FRAME_DONE_o,
   output logic               BUSY_o
);
   localparam int unsigned PW = C_LEN_W + 1;

   typedef enum logic [1:0] {IDLE, WAIT_RDY, CHIRP, GAP} state_t;

   state_t           state, state_n;
   logic [PW-1:0]    clen, glen, rxdly;
   logic [PW-1:0]    ph, ph_n;
   logic [C_N_W-1:0] nchirp, idx_n;
   logic             latch, done_n, start_n, tick, last_chirp, eoc;
   logic [PW-1:0]    chirp_end, period_end, win_hi;

   // the tick coinciding with the start pulse belongs to no phase
   assign tick       = SMP_EE_i && !TX_START_o;
   assign chirp_end  = clen - PW'(1);
   assign period_end = clen + glen - PW'(1);
   assign win_hi     = rxdly + clen;
   // NCHIRP of zero wraps to the all-ones index, giving a full 2^C_N_W frame
   assign last_chirp = (CHIRP_IDX_o == nchirp - C_N_W'(1));

   always_comb begin
      state_n = state;
      ph_n    = ph;
      idx_n   = CHIRP_IDX_o;
      latch   = 1'b0;
      done_n  = 1'b0;
      start_n = 1'b0;
      eoc     = 1'b0;
      unique case (state)
         IDLE: begin
            if (EN_i) begin
               latch   = 1'b1;
               idx_n   = '0;
               state_n = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (!EN_i) begin
               state_n = IDLE;
            end else if (TX_RDY_i) begin
               state_n = CHIRP;
               start_n = 1'b1;
               ph_n    = '0;
            end
         end
         CHIRP: begin
            if (tick) begin
               ph_n = ph + PW'(1);
               if (ph == chirp_end) begin
                  if (glen == '0) eoc = 1'b1;
                  else            state_n = GAP;
               end
            end
         end
         GAP: begin
            if (tick) begin
               ph_n = ph + PW'(1);
               if (ph == period_end) eoc = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (eoc) begin
         if (last_chirp) begin
            done_n = 1'b1;
            if (EN_i) begin
               latch   = 1'b1;
               idx_n   = '0;
               state_n = WAIT_RDY;
            end else begin
               state_n = IDLE;
            end
         end else if (!EN_i) begin
            state_n = IDLE;
         end else begin
            idx_n   = CHIRP_IDX_o + C_N_W'(1);
            state_n = WAIT_RDY;
         end
      end
   end

   always_ff @(posedge CK_i or posedge ARST_i) begin
      if (ARST_i) begin
         state        <= IDLE;
         ph           <= '0;
         clen         <= '0;
         glen         <= '0;
         rxdly        <= '0;
         nchirp       <= '0;
         TX_START_o   <= 1'b0;
         TX_ACT_o     <= 1'b0;
         RX_WIN_o     <= 1'b0;
         CHIRP_IDX_o  <= '0;
         FRAME_DONE_o <= 1'b0;
         BUSY_o       <= 1'b0;
      end else begin
         state <= state_n;
         ph    <= ph_n;
         if (latch) begin
            clen   <= (CHIRP_LEN_i == '0) ? PW'(1) : PW'(CHIRP_LEN_i);
            glen   <= PW'(GAP_LEN_i);
            rxdly  <= PW'(RX_DLY_i);
            nchirp <= NCHIRP_i;
         end
         // outputs follow the next state so they line up with it cycle for cycle
         TX_START_o   <= start_n;
         TX_ACT_o     <= (state_n == CHIRP);
         RX_WIN_o     <= ((state_n == CHIRP) || (state_n == GAP)) &&
                         (ph_n >= rxdly) && (ph_n < win_hi);
         CHIRP_IDX_o  <= idx_n;
         FRAME_DONE_o <= done_n;
         BUSY_o       <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_sswfmcw_sweep_sched.sv
// Directed bench for sswfmcw_sweep_sched: frame sequencing, RX window, abort,
// TX_RDY stall, edge values and asynchronous reset.
module tb_sswfmcw_sweep_sched;
   logic        ck = 1'b0;
   logic        arst = 1'b1;
   logic        en = 1'b0;
   logic        smp_ee = 1'b0;
   logic [15:0] chirp_len = '0;
   logic [15:0] gap_len = '0;
   logic [15:0] rx_dly = '0;
   logic [7:0]  nchirp = '0;
   logic        tx_rdy = 1'b0;
   logic        tx_start, tx_act, rx_win, frame_done, busy;
   logic [7:0]  chirp_idx;

   int checks = 0;
   int errors = 0;
   int unsigned tick_div = 1;
   int unsigned tick_cnt = 0;

   sswfmcw_sweep_sched #(.C_LEN_W(16), .C_N_W(8)) dut (
      .CK_i(ck), .ARST_i(arst), .EN_i(en), .SMP_EE_i(smp_ee),
      .CHIRP_LEN_i(chirp_len), .GAP_LEN_i(gap_len), .RX_DLY_i(rx_dly),
      .NCHIRP_i(nchirp), .TX_RDY_i(tx_rdy),
      .TX_START_o(tx_start), .TX_ACT_o(tx_act), .RX_WIN_o(rx_win),
      .CHIRP_IDX_o(chirp_idx), .FRAME_DONE_o(frame_done), .BUSY_o(busy)
   );

   always #5 ck = ~ck;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // one clock; outputs are sampled 1 unit after the edge, smp_ee set for the next cycle
   task automatic step();
      @(posedge ck);
      #1;
      tick_cnt = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
      smp_ee = (tick_cnt == 0);
   endtask

   task automatic do_reset();
      en = 1'b0; tx_rdy = 1'b0;
      tick_div = 1; tick_cnt = 0; smp_ee = 1'b1;
      arst = 1'b1;
      step(); step();
      arst = 1'b0;
      step();
   endtask

   task automatic wait_start(input int unsigned limit, output bit ok);
      int unsigned n = 0;
      while (tx_start !== 1'b1 && n < limit) begin
         step();
         n++;
      end
      ok = (tx_start === 1'b1);
   endtask

   task automatic test_reset();
      arst = 1'b1;
      #1;
      checks += 6;
      if (tx_start !== 1'b0)   begin errors++; $display("FAIL rst_start got %b want 0", tx_start); end
      if (tx_act !== 1'b0)     begin errors++; $display("FAIL rst_act got %b want 0", tx_act); end
      if (rx_win !== 1'b0)     begin errors++; $display("FAIL rst_rx got %b want 0", rx_win); end
      if (chirp_idx !== 8'd0)  begin errors++; $display("FAIL rst_idx got %0d want 0", chirp_idx); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", frame_done); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      do_reset();
      step(); step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_basic_frame();
      int unsigned starts = 0, act_ticks = 0, rx_ticks = 0, n = 0;
      logic [23:0] idx_log = '0;
      bit done_seen = 1'b0;
      do_reset();
      chirp_len = 16'd4; gap_len = 16'd2; rx_dly = 16'd1; nchirp = 8'd3; tx_rdy = 1'b1;
      tick_div = 4; tick_cnt = 0; smp_ee = 1'b1;
      en = 1'b1;
      while (n < 400) begin
         if (frame_done === 1'b1) begin
            done_seen = 1'b1;
            break;
         end
         if (tx_start === 1'b1) begin
            starts++;
            idx_log = {idx_log[15:0], chirp_idx};
            chirp_len = 16'd9;
         end
         if (smp_ee && tx_act === 1'b1 && tx_start !== 1'b1) act_ticks++;
         if (smp_ee && rx_win === 1'b1) rx_ticks++;
         step();
         n++;
      end
      checks += 9;
      if (!done_seen)               begin errors++; $display("FAIL basic_done_timeout got 0 want 1"); end
      if (starts != 3)              begin errors++; $display("FAIL basic_starts got %0d want 3", starts); end
      if (act_ticks != 12)          begin errors++; $display("FAIL basic_act_ticks got %0d want 12", act_ticks); end
      if (rx_ticks != 12)           begin errors++; $display("FAIL basic_rx_ticks got %0d want 12", rx_ticks); end
      if (idx_log !== 24'h000102)   begin errors++; $display("FAIL basic_idx_seq got %h want 000102", idx_log); end
      if (tx_act !== 1'b0)          begin errors++; $display("FAIL basic_done_act got %b want 0", tx_act); end
      if (rx_win !== 1'b0)          begin errors++; $display("FAIL basic_done_rx got %b want 0", rx_win); end
      if (chirp_idx !== 8'd0)       begin errors++; $display("FAIL basic_done_idx got %0d want 0", chirp_idx); end
      if (busy !== 1'b1)            begin errors++; $display("FAIL basic_done_busy got %b want 1", busy); end
      step();
      checks += 2;
      if (tx_start !== 1'b1)   begin errors++; $display("FAIL basic_restart got %b want 1", tx_start); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", frame_done); end
   endtask

   task automatic test_gap_zero();
      logic [0:11] p_start = 12'b100000100000;
      logic [0:11] p_act   = 12'b111110111110;
      logic [0:11] p_rx    = 12'b000010000010;
      logic [0:11] p_done  = 12'b000000000001;
      logic [0:11] p_idx   = 12'b000001111110;
      do_reset();
      chirp_len = 16'd4; gap_len = 16'd0; rx_dly = 16'd3; nchirp = 8'd2; tx_rdy = 1'b1;
      en = 1'b1;
      step();
      checks += 2;
      if (busy !== 1'b1)     begin errors++; $display("FAIL gz_latch_busy got %b want 1", busy); end
      if (tx_start !== 1'b0) begin errors++; $display("FAIL gz_latch_start got %b want 0", tx_start); end
      step();
      for (int k = 0; k < 12; k++) begin
         checks += 6;
         if (tx_start !== p_start[k])   begin errors++; $display("FAIL gz_start k=%0d got %b want %b", k, tx_start, p_start[k]); end
         if (tx_act !== p_act[k])       begin errors++; $display("FAIL gz_act k=%0d got %b want %b", k, tx_act, p_act[k]); end
         if (rx_win !== p_rx[k])        begin errors++; $display("FAIL gz_rx k=%0d got %b want %b", k, rx_win, p_rx[k]); end
         if (frame_done !== p_done[k])  begin errors++; $display("FAIL gz_done k=%0d got %b want %b", k, frame_done, p_done[k]); end
         if (chirp_idx !== {7'd0, p_idx[k]}) begin errors++; $display("FAIL gz_idx k=%0d got %0d want %0d", k, chirp_idx, p_idx[k]); end
         if (busy !== 1'b1)             begin errors++; $display("FAIL gz_busy k=%0d got %b want 1", k, busy); end
         step();
      end
   endtask

   task automatic test_rdy_stall();
      logic [0:4] p_act  = 5'b11100;
      logic [0:4] p_rx   = 5'b11100;
      logic [0:4] p_done = 5'b00001;
      do_reset();
      chirp_len = 16'd2; gap_len = 16'd1; rx_dly = 16'd0; nchirp = 8'd1; tx_rdy = 1'b0;
      en = 1'b1;
      step();
      for (int k = 0; k < 10; k++) begin
         checks += 4;
         if (busy !== 1'b1)     begin errors++; $display("FAIL stall_busy k=%0d got %b want 1", k, busy); end
         if (tx_start !== 1'b0) begin errors++; $display("FAIL stall_start k=%0d got %b want 0", k, tx_start); end
         if (tx_act !== 1'b0)   begin errors++; $display("FAIL stall_act k=%0d got %b want 0", k, tx_act); end
         if (rx_win !== 1'b0)   begin errors++; $display("FAIL stall_rx k=%0d got %b want 0", k, rx_win); end
         step();
      end
      tx_rdy = 1'b1;
      step();
      checks++;
      if (tx_start !== 1'b1) begin errors++; $display("FAIL stall_release_start got %b want 1", tx_start); end
      for (int k = 0; k < 5; k++) begin
         checks += 3;
         if (tx_act !== p_act[k])      begin errors++; $display("FAIL stall_act_seq k=%0d got %b want %b", k, tx_act, p_act[k]); end
         if (rx_win !== p_rx[k])       begin errors++; $display("FAIL stall_rx_seq k=%0d got %b want %b", k, rx_win, p_rx[k]); end
         if (frame_done !== p_done[k]) begin errors++; $display("FAIL stall_done k=%0d got %b want %b", k, frame_done, p_done[k]); end
         step();
      end
   endtask

   task automatic test_en_abort();
      logic [0:9] p_start = 10'b1000000000;
      logic [0:9] p_act   = 10'b1111100000;
      logic [0:9] p_busy  = 10'b1111111000;
      logic [0:9] p_rx    = 10'b0011110000;
      bit ok;
      do_reset();
      chirp_len = 16'd4; gap_len = 16'd2; rx_dly = 16'd1; nchirp = 8'd4; tx_rdy = 1'b1;
      en = 1'b1;
      wait_start(20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL abort_first_start got 0 want 1"); end
      step();
      wait_start(20, ok);
      checks += 2;
      if (!ok)                begin errors++; $display("FAIL abort_second_start got 0 want 1"); end
      if (chirp_idx !== 8'd1) begin errors++; $display("FAIL abort_idx got %0d want 1", chirp_idx); end
      for (int k = 0; k < 10; k++) begin
         if (k == 2) en = 1'b0;
         checks += 6;
         if (tx_start !== p_start[k]) begin errors++; $display("FAIL abort_start k=%0d got %b want %b", k, tx_start, p_start[k]); end
         if (tx_act !== p_act[k])     begin errors++; $display("FAIL abort_act k=%0d got %b want %b", k, tx_act, p_act[k]); end
         if (busy !== p_busy[k])      begin errors++; $display("FAIL abort_busy k=%0d got %b want %b", k, busy, p_busy[k]); end
         if (rx_win !== p_rx[k])      begin errors++; $display("FAIL abort_rx k=%0d got %b want %b", k, rx_win, p_rx[k]); end
         if (frame_done !== 1'b0)     begin errors++; $display("FAIL abort_done k=%0d got %b want 0", k, frame_done); end
         if (chirp_idx !== 8'd1)      begin errors++; $display("FAIL abort_idx_hold k=%0d got %0d want 1", k, chirp_idx); end
         step();
      end
   endtask

   task automatic test_edge_values();
      int unsigned starts = 0, act_cycles = 0, rx_cycles = 0, n = 0;
      logic [7:0] last_idx = '0;
      bit done_seen = 1'b0;
      do_reset();
      chirp_len = 16'd0; gap_len = 16'd0; rx_dly = 16'hFFFF; nchirp = 8'd0; tx_rdy = 1'b1;
      en = 1'b1;
      while (n < 1500) begin
         if (frame_done === 1'b1) begin
            done_seen = 1'b1;
            break;
         end
         if (tx_start === 1'b1) begin
            starts++;
            last_idx = chirp_idx;
         end
         if (tx_act === 1'b1) act_cycles++;
         if (rx_win === 1'b1) rx_cycles++;
         step();
         n++;
      end
      checks += 5;
      if (!done_seen)          begin errors++; $display("FAIL edge_done_timeout got 0 want 1"); end
      if (starts != 256)       begin errors++; $display("FAIL edge_starts got %0d want 256", starts); end
      if (last_idx !== 8'd255) begin errors++; $display("FAIL edge_last_idx got %0d want 255", last_idx); end
      if (act_cycles != 512)   begin errors++; $display("FAIL edge_act_cycles got %0d want 512", act_cycles); end
      if (rx_cycles != 0)      begin errors++; $display("FAIL edge_rx_cycles got %0d want 0", rx_cycles); end
   endtask

   task automatic test_arst_mid_gap();
      logic [0:3] p_act  = 4'b1110;
      logic [0:3] p_done = 4'b0001;
      bit ok;
      do_reset();
      chirp_len = 16'd4; gap_len = 16'd4; rx_dly = 16'd0; nchirp = 8'd3; tx_rdy = 1'b1;
      en = 1'b1;
      wait_start(20, ok);
      step();
      wait_start(20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL arst_start_timeout got 0 want 1"); end
      for (int k = 0; k < 6; k++) step();
      checks += 3;
      if (busy !== 1'b1)      begin errors++; $display("FAIL arst_pre_busy got %b want 1", busy); end
      if (tx_act !== 1'b0)    begin errors++; $display("FAIL arst_pre_act got %b want 0", tx_act); end
      if (chirp_idx !== 8'd1) begin errors++; $display("FAIL arst_pre_idx got %0d want 1", chirp_idx); end
      #2;
      arst = 1'b1;
      #1;
      checks += 6;
      if (tx_start !== 1'b0)   begin errors++; $display("FAIL arst_start got %b want 0", tx_start); end
      if (tx_act !== 1'b0)     begin errors++; $display("FAIL arst_act got %b want 0", tx_act); end
      if (rx_win !== 1'b0)     begin errors++; $display("FAIL arst_rx got %b want 0", rx_win); end
      if (chirp_idx !== 8'd0)  begin errors++; $display("FAIL arst_idx got %0d want 0", chirp_idx); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL arst_done got %b want 0", frame_done); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
      chirp_len = 16'd2; gap_len = 16'd0; nchirp = 8'd1;
      step();
      arst = 1'b0;
      step();
      checks += 2;
      if (busy !== 1'b1)     begin errors++; $display("FAIL arst_relatch_busy got %b want 1", busy); end
      if (tx_start !== 1'b0) begin errors++; $display("FAIL arst_relatch_start got %b want 0", tx_start); end
      step();
      checks++;
      if (tx_start !== 1'b1) begin errors++; $display("FAIL arst_first_start got %b want 1", tx_start); end
      for (int k = 0; k < 4; k++) begin
         checks += 3;
         if (tx_act !== p_act[k])      begin errors++; $display("FAIL arst_new_act k=%0d got %b want %b", k, tx_act, p_act[k]); end
         if (frame_done !== p_done[k]) begin errors++; $display("FAIL arst_new_done k=%0d got %b want %b", k, frame_done, p_done[k]); end
         if (chirp_idx !== 8'd0)       begin errors++; $display("FAIL arst_new_idx k=%0d got %0d want 0", k, chirp_idx); end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_gap_zero();
      test_rdy_stall();
      test_en_abort();
      test_edge_values();
      test_arst_mid_gap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
